mem_access_stage: RTL and testbench

- Load/store stage directly downstream of the execute stage.
- Consumes the ALU result, memory address, store data and control from execute, and runs one data-bus transaction for loads and stores.
- Aligns byte lanes, sign/zero-extends load data and presents a single registered result to writeback.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage_if.sv | 51 +++++
 rtl/mem_access_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: execute-side inputs, data bus and writeback signals of
// the load/store stage. "master" is the stage's view, "slave" is the view of
// the surrounding pipeline and memory.
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    // execute side
    logic              in_valid;
    logic              in_ready;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       alu_result;
    logic [4:0]        rd;
    logic              reg_write;
    // data bus
    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [31:0]       dbus_wdata;
    logic [3:0]        dbus_wstrb;
    logic              dbus_gnt;
    logic              dbus_rvalid;
    logic [31:0]       dbus_rdata;
    // writeback side
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic [31:0]       wb_data;
    logic              misalign;
    logic              bus_err;

    modport master (
        input  in_valid, mem_read, mem_write, funct3, mem_addr, mem_wdata,
               alu_result, rd, reg_write, dbus_gnt, dbus_rvalid, dbus_rdata,
               wb_ready,
        output in_ready, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
               wb_valid, wb_rd, wb_reg_write, wb_data, misalign, bus_err
    );

    modport slave (
        output in_valid, mem_read, mem_write, funct3, mem_addr, mem_wdata,
               alu_result, rd, reg_write, dbus_gnt, dbus_rvalid, dbus_rdata,
               wb_ready,
        input  in_ready, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
               wb_valid, wb_rd, wb_reg_write, wb_data, misalign, bus_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage between execute and writeback.
// Runs one data-bus transaction per load/store, aligns byte lanes,
// sign/zero-extends load data and holds one registered result for writeback.
// Build option: define MEM_TIMEOUT_EN to add a bus watchdog that abandons a
// transaction after TIMEOUT_CYCLES and reports bus_err.
module mem_access_stage #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_stage_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} sz_t;

    state_t      state_q, state_d;

    // captured instruction
    logic [31:0] addr_q;
    logic        we_q;
    sz_t         size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [4:0]  rd_q;

    // writeback result
    logic [31:0] wb_data_q;
    logic        wb_regw_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic        in_ready;
    logic        accept;
    logic        is_mem;
    logic        mis_in;
    sz_t         size_in;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic        load_done;
    logic        tmo_hit;
    logic        timeout_fire;
    logic        dbus_active;
    logic        wb_active;

    assign wb_active   = (state_q == RESP);
    assign dbus_active = (state_q == REQ);
    assign in_ready    = (state_q == IDLE) && !wb_active;
    assign accept      = bus.in_valid && in_ready;
    assign is_mem      = bus.mem_read || bus.mem_write;

    // Access size decode; anything that is not a byte or half form is a word.
    always_comb begin
        case (bus.funct3)
            3'b000, 3'b100: size_in = SZ_BYTE;
            3'b001, 3'b101: size_in = SZ_HALF;
            default:        size_in = SZ_WORD;
        endcase
    end

    assign mis_in = is_mem &&
                    (((size_in == SZ_HALF) && bus.mem_addr[0]) ||
                     ((size_in == SZ_WORD) && (bus.mem_addr[1:0] != 2'b00)));

    // Store lane replication and byte enables, computed at accept.
    always_comb begin
        st_wdata = '0;
        st_wstrb = 4'b0000;
        if (bus.mem_write) begin
            case (size_in)
                SZ_BYTE: begin
                    st_wdata = {4{bus.mem_wdata[7:0]}};
                    st_wstrb = 4'b0001 << bus.mem_addr[1:0];
                end
                SZ_HALF: begin
                    st_wdata = {2{bus.mem_wdata[15:0]}};
                    st_wstrb = 4'b0011 << bus.mem_addr[1:0];
                end
                default: begin
                    st_wdata = bus.mem_wdata;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Load lane select and sign/zero extension of the returned word.
    always_comb begin
        lane_b = '0;
        case (addr_q[1:0])
            2'd0: lane_b = bus.dbus_rdata[7:0];
            2'd1: lane_b = bus.dbus_rdata[15:8];
            2'd2: lane_b = bus.dbus_rdata[23:16];
            2'd3: lane_b = bus.dbus_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = bus.dbus_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Watchdog: zero outside a transaction (so zero on REQ entry), counts
    // through REQ and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_LIMIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_hit = 1'b0;
`endif

    // Grant / read data win over a watchdog expiry in the same cycle.
    assign timeout_fire = tmo_hit && (((state_q == REQ) && !bus.dbus_gnt) ||
                                      ((state_q == WAIT) && !bus.dbus_rvalid));
    assign load_done    = (state_q == WAIT) && bus.dbus_rvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (is_mem && !mis_in) ? REQ : RESP;
                end
            end
            REQ: begin
                if (bus.dbus_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_fire) begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (load_done || timeout_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction capture and writeback result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            wb_regw_q  <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= bus.mem_addr;
                we_q       <= bus.mem_write;
                size_q     <= size_in;
                uns_q      <= bus.funct3[2];
                wdata_q    <= st_wdata;
                wstrb_q    <= st_wstrb;
                rd_q       <= bus.rd;
                wb_data_q  <= mis_in ? bus.mem_addr : bus.alu_result;
                wb_regw_q  <= bus.reg_write && (bus.rd != 5'd0) && !mis_in && !bus.mem_write;
                misalign_q <= mis_in;
                bus_err_q  <= 1'b0;
            end
            if (load_done) begin
                wb_data_q <= load_ext;
            end
            if (timeout_fire) begin
                bus_err_q <= 1'b1;
                wb_regw_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = in_ready;

    assign bus.dbus_req     = dbus_active;
    assign bus.dbus_we      = dbus_active && we_q;
    assign bus.dbus_addr    = dbus_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.dbus_wdata   = dbus_active ? wdata_q : '0;
    assign bus.dbus_wstrb   = dbus_active ? wstrb_q : '0;

    assign bus.wb_valid     = wb_active;
    assign bus.wb_rd        = wb_active ? rd_q : '0;
    assign bus.wb_reg_write = wb_active && wb_regw_q;
    assign bus.wb_data      = wb_active ? wb_data_q : '0;
    assign bus.misalign     = wb_active && misalign_q;
    assign bus.bus_err      = wb_active && bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage.
// Define MEM_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regw;
        logic        mis;
        logic        err;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    wb_t         sb[$];

    mem_access_stage_if #(.ADDR_W(32)) bus ();

    mem_access_stage #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    function automatic wb_t wb_now();
        return {bus.wb_data, bus.wb_rd, bus.wb_reg_write, bus.misalign, bus.bus_err};
    endfunction

    function automatic logic [37:0] dbus_ctl();
        return {bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_wstrb};
    endfunction

    function automatic logic [69:0] dbus_full();
        return {bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_wdata, bus.dbus_wstrb};
    endfunction

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.funct3      = 3'b000;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.alu_result  = '0;
        bus.rd          = '0;
        bus.reg_write   = 1'b0;
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        bus.dbus_rdata  = '0;
    endtask

    // Present one instruction from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [4:0] r, input logic rw);
        int unsigned k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_ready: in_ready=%b, required 1", bus.in_ready);
        end
        bus.in_valid   = 1'b1;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        bus.funct3     = f3;
        bus.mem_addr   = a;
        bus.mem_wdata  = wd;
        bus.alu_result = alu;
        bus.rd         = r;
        bus.reg_write  = rw;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
    endtask

    task automatic wait_wb(output bit seen);
        int unsigned k = 0;
        while (bus.wb_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        seen = (bus.wb_valid === 1'b1);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.wb_ready    = 1'b1;
        rst             = 1'b1;
        bus.dbus_gnt    = 1'b1;
        bus.dbus_rvalid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dbus_full(), wb_now(), bus.wb_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dbus=%h wb=%h valid=%b, required all 0",
                     dbus_full(), wb_now(), bus.wb_valid);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stray_bus: got wb_valid=%b dbus_req=%b, required 0 0",
                     bus.wb_valid, bus.dbus_req);
        end
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [31:0] alu[3] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0F0F_0F0F};
        logic [4:0]  rdv[3] = '{5'd5, 5'd0, 5'd31};
        logic        rwv[3] = '{1'b1, 1'b1, 1'b0};
        wb_t e;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = '{data: alu[i], rd: rdv[i], regw: rwv[i] && (rdv[i] != 5'd0), mis: 1'b0, err: 1'b0};
            sb.push_back(e);
            // misaligned address on a non-memory op must not raise misalign
            issue(1'b0, 1'b0, 3'b010, 32'h0000_0003, 32'h0, alu[i], rdv[i], rwv[i]);
            n_cmp++;
            if (bus.wb_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_latency[%0d]: wb_valid=%b, required 1", i, bus.wb_valid);
            end
            e = sb.pop_front();
            n_cmp++;
            if (wb_now() !== e) begin
                n_fail++;
                $display("FAIL alu_wb[%0d]: got %h, required %h", i, wb_now(), e);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_release[%0d]: got valid=%b ready=%b, required 0 1",
                         i, bus.wb_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3[8]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b011, 3'b001};
        logic [31:0] ad[8]  = '{32'h1003, 32'h1003, 32'h1002, 32'h1000,
                                32'h1001, 32'h1004, 32'h1008, 32'h1000};
        logic [31:0] rdv[8] = '{32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC, 32'h1234F00D,
                                32'h1234F00D, 32'hCAFEBABE, 32'h00000081, 32'h00007FFF};
        int unsigned dly[8] = '{0, 0, 2, 0, 1, 1, 0, 3};
        logic [31:0] ex[8]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA, 32'h0000F00D,
                                32'hFFFFFFF0, 32'hCAFEBABE, 32'h00000081, 32'h00007FFF};
        wb_t         e;
        logic [31:0] a;
        logic [37:0] ctl;
        bit          seen;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = '{data: ex[i], rd: 5'(10 + i), regw: 1'b1, mis: 1'b0, err: 1'b0};
            sb.push_back(e);
            issue(1'b1, 1'b0, f3[i], ad[i], 32'h0, 32'hFFFF_0000, 5'(10 + i), 1'b1);
            a   = ad[i];
            ctl = {1'b1, 1'b0, a[31:2], 2'b00, 4'b0000};
            n_cmp++;
            if (dbus_ctl() !== ctl) begin
                n_fail++;
                $display("FAIL load_req[%0d]: got %h, required %h", i, dbus_ctl(), ctl);
            end
            for (int unsigned d = 0; d < dly[i]; d++) begin
                @(negedge clk);
                n_cmp++;
                if (dbus_ctl() !== ctl) begin
                    n_fail++;
                    $display("FAIL load_hold[%0d]: got %h, required %h", i, dbus_ctl(), ctl);
                end
            end
            bus.dbus_gnt = 1'b1;
            @(negedge clk);
            bus.dbus_gnt = 1'b0;
            n_cmp++;
            if (bus.dbus_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_gnt[%0d]: got req=%b valid=%b, required 0 0",
                         i, bus.dbus_req, bus.wb_valid);
            end
            bus.dbus_rvalid = 1'b1;
            bus.dbus_rdata  = rdv[i];
            @(negedge clk);
            bus.dbus_rvalid = 1'b0;
            bus.dbus_rdata  = 32'h5A5A_0000;
            wait_wb(seen);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || wb_now() !== e) begin
                n_fail++;
                $display("FAIL load_wb[%0d]: got %h (valid=%b), required %h", i, wb_now(), seen, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3[5]  = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] ad[5]  = '{32'h2002, 32'h3001, 32'h3003, 32'h4000, 32'h2000};
        logic [31:0] wd[5]  = '{32'h0000BEEF, 32'h123456A5, 32'h0000007E, 32'h12345678, 32'hFFFF1234};
        logic [31:0] xa[5]  = '{32'h2000, 32'h3000, 32'h3000, 32'h4000, 32'h2000};
        logic [31:0] xd[5]  = '{32'hBEEFBEEF, 32'hA5A5A5A5, 32'h7E7E7E7E, 32'h12345678, 32'h12341234};
        logic [3:0]  xs[5]  = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        int unsigned dly[5] = '{0, 1, 3, 0, 2};
        wb_t         e;
        logic [69:0] full;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = '{data: 32'h0, rd: 5'd6, regw: 1'b0, mis: 1'b0, err: 1'b0};
            sb.push_back(e);
            issue(1'b0, 1'b1, f3[i], ad[i], wd[i], 32'h0000_0777, 5'd6, 1'(i % 2));
            full = {1'b1, 1'b1, xa[i], xd[i], xs[i]};
            n_cmp++;
            if (dbus_full() !== full) begin
                n_fail++;
                $display("FAIL store_req[%0d]: got %h, required %h", i, dbus_full(), full);
            end
            for (int unsigned d = 0; d < dly[i]; d++) begin
                @(negedge clk);
                n_cmp++;
                if (dbus_full() !== full) begin
                    n_fail++;
                    $display("FAIL store_hold[%0d]: got %h, required %h", i, dbus_full(), full);
                end
            end
            bus.dbus_gnt = 1'b1;
            @(negedge clk);
            bus.dbus_gnt = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if ({bus.wb_valid, bus.dbus_req, bus.wb_rd, bus.wb_reg_write, bus.misalign, bus.bus_err}
                !== {1'b1, 1'b0, e.rd, e.regw, e.mis, e.err}) begin
                n_fail++;
                $display("FAIL store_wb[%0d]: got valid=%b req=%b rd=%0d regw=%b mis=%b err=%b, required 1 0 %0d %b %b %b",
                         i, bus.wb_valid, bus.dbus_req, bus.wb_rd, bus.wb_reg_write, bus.misalign,
                         bus.bus_err, e.rd, e.regw, e.mis, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  f3[5] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b101};
        logic [31:0] ad[5] = '{32'h1002, 32'h1001, 32'h2003, 32'h2005, 32'h1003};
        logic        wr[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        wb_t e;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = '{data: ad[i], rd: 5'd3, regw: 1'b0, mis: 1'b1, err: 1'b0};
            sb.push_back(e);
            issue(!wr[i], wr[i], f3[i], ad[i], 32'h1111_2222, 32'h0, 5'd3, 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (bus.wb_valid !== 1'b1 || bus.dbus_req !== 1'b0 || wb_now() !== e) begin
                n_fail++;
                $display("FAIL misalign[%0d]: got valid=%b req=%b wb=%h, required 1 0 %h",
                         i, bus.wb_valid, bus.dbus_req, wb_now(), e);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.dbus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_no_req[%0d]: dbus_req=%b, required 0", i, bus.dbus_req);
            end
        end
        // reset while a load request is on the bus
        issue(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 5'd8, 1'b1);
        n_cmp++;
        if (bus.dbus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_req_pre: dbus_req=%b, required 1", bus.dbus_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.dbus_req, bus.wb_valid, bus.in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_mid_req: got req/valid/ready=%b%b%b, required 001",
                     bus.dbus_req, bus.wb_valid, bus.in_ready);
        end
        bus.dbus_gnt    = 1'b1;
        bus.dbus_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abandon: got valid=%b req=%b, required 0 0", bus.wb_valid, bus.dbus_req);
        end
    endtask

    task automatic test_backpressure();
        wb_t e;
        bit  seen;
        bus.wb_ready = 1'b0;
        sb.push_back('{data: 32'hCAFE_0001, rd: 5'd9, regw: 1'b1, mis: 1'b0, err: 1'b0});
        sb.push_back('{data: 32'h5555_AAAA, rd: 5'd12, regw: 1'b1, mis: 1'b0, err: 1'b0});
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFE_0001, 5'd9, 1'b1);
        bus.in_valid   = 1'b1;
        bus.alu_result = 32'h5555_AAAA;
        bus.rd         = 5'd12;
        bus.reg_write  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({bus.wb_valid, bus.in_ready, wb_now()} !== {1'b1, 1'b0, sb[0]}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b wb=%h, required 1 0 %h",
                         k, bus.wb_valid, bus.in_ready, wb_now(), sb[0]);
            end
            @(negedge clk);
        end
        bus.wb_ready = 1'b1;
        e = sb.pop_front();
        @(negedge clk);
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b, required 0 1", bus.wb_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_wb(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || wb_now() !== e) begin
            n_fail++;
            $display("FAIL bp_second: got %h (valid=%b), required %h", wb_now(), seen, e);
        end
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        wb_t         e;
        int unsigned cyc;
        bit          seen;
        bus.wb_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            sb.push_back('{data: 32'h0, rd: 5'd4, regw: 1'b0, mis: 1'b0, err: 1'b1});
            issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 5'd4, 1'b1);
            cyc = 0;
            if (m == 1) begin
                bus.dbus_gnt = 1'b1;
                @(negedge clk);
                bus.dbus_gnt = 1'b0;
                cyc = 1;
            end
            while (bus.wb_valid !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            n_cmp++;
            if (cyc != 5) begin
                n_fail++;
                $display("FAIL tmo_latency[%0d]: got %0d cycles, required 5", m, cyc);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({bus.dbus_req, bus.wb_rd, bus.wb_reg_write, bus.misalign, bus.bus_err}
                !== {1'b0, e.rd, e.regw, e.mis, e.err}) begin
                n_fail++;
                $display("FAIL tmo_wb[%0d]: got req=%b rd=%0d regw=%b mis=%b err=%b, required 0 %0d %b %b %b",
                         m, bus.dbus_req, bus.wb_rd, bus.wb_reg_write, bus.misalign, bus.bus_err,
                         e.rd, e.regw, e.mis, e.err);
            end
            @(negedge clk);
            bus.dbus_rvalid = 1'b1;
            bus.dbus_rdata  = 32'h0BAD_0BAD;
            repeat (2) @(negedge clk);
            bus.dbus_rvalid = 1'b0;
            n_cmp++;
            if (bus.wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_late_rvalid[%0d]: wb_valid=%b, required 0", m, bus.wb_valid);
            end
        end
        sb.push_back('{data: 32'h0000_00AB, rd: 5'd2, regw: 1'b1, mis: 1'b0, err: 1'b0});
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_00AB, 5'd2, 1'b1);
        wait_wb(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || wb_now() !== e) begin
            n_fail++;
            $display("FAIL tmo_recover: got %h, required %h", wb_now(), e);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_backpressure();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
